// File: rtl/agc_pkg.sv
// agc_pkg: word widths, ALU opcodes, sequencer states and ones-complement helpers
// shared by agc_alu_seq and agc_muldiv_core.
package agc_pkg;

    localparam int W     = 16;
    localparam int MAG_W = W - 1;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(MAG_W);

    localparam logic [2:0] OP_AD   = 3'd0;
    localparam logic [2:0] OP_SU   = 3'd1;
    localparam logic [2:0] OP_MASK = 3'd2;
    localparam logic [2:0] OP_MP0  = 3'd3;
    localparam logic [2:0] OP_MP1  = 3'd4;
    localparam logic [2:0] OP_DV0  = 3'd5;
    localparam logic [2:0] OP_DV1  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DIV,
        S_FIN
    } state_t;

    function automatic logic [W-1:0] oc_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        // A carry-out leaves at most 0xFFFE, so folding it back cannot wrap again.
        return sum[W-1:0] + W'(sum[W]);
    endfunction

    function automatic logic [W-1:0] oc_neg(input logic [W-1:0] v);
        return ~v;
    endfunction

    function automatic logic [MAG_W-1:0] oc_mag(input logic [W-1:0] v);
        return v[W-1] ? ~v[W-2:0] : v[W-2:0];
    endfunction

    function automatic logic [W-1:0] oc_signed(input logic s, input logic [MAG_W-1:0] m);
        return s ? oc_neg({1'b0, m}) : {1'b0, m};
    endfunction

endpackage

// File: rtl/agc_muldiv_core.sv
// agc_muldiv_core: iterative engine for MP0 (shift-add) and DV0 (restoring divide),
// holding the MP1 high word and DV1 quotient. Option: ALU_MP_EARLY_TERM_EN.
module agc_muldiv_core
    import agc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             mul_start_i,
    input  logic             div_start_i,
    input  logic             div_sat_i,
    input  logic [MAG_W-1:0] x_mag_i,
    input  logic [MAG_W-1:0] y_mag_i,
    input  logic             prod_sign_i,
    input  logic             x_sign_i,
    output logic             iter_done_o,
    output logic [W-1:0]     lo_word_o,
    output logic [W-1:0]     hi_word_o,
    output logic [W-1:0]     quo_word_o
);

    logic                 active_q;
    logic                 is_div_q;
    logic                 sign_q;
    logic                 x_sign_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*MAG_W-1:0]   acc_q;
    logic [2*MAG_W-1:0]   mcand_q;
    logic [MAG_W-1:0]     mq_q;
    logic [W-1:0]         hi_q;
    logic [W-1:0]         quo_q;

    logic                 last_iter;
    logic [2*MAG_W-1:0]   mul_sum;
    logic [MAG_W:0]       rem2;
    logic [MAG_W:0]       div_diff;
    logic                 div_fit;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        mul_sum   = acc_q + mcand_q;
        rem2      = {acc_q[MAG_W-1:0], 1'b0};
        div_diff  = rem2 - {1'b0, mcand_q[MAG_W-1:0]};
        div_fit   = rem2 >= {1'b0, mcand_q[MAG_W-1:0]};
        last_iter = (cnt_q == ITER_LAST);
`ifdef ALU_MP_EARLY_TERM_EN
        if (!is_div_q && cnt_q != '0 && mq_q == '0) begin
            last_iter = 1'b1;
        end
`endif
        iter_done_o = active_q && last_iter;
        lo_word_o   = oc_signed(is_div_q ? x_sign_q : sign_q, acc_q[MAG_W-1:0]);
        hi_word_o   = hi_q;
        quo_word_o  = quo_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            is_div_q <= 1'b0;
            sign_q   <= 1'b0;
            x_sign_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mq_q     <= '0;
            hi_q     <= '0;
            quo_q    <= '0;
        end else if (mul_start_i || div_start_i) begin
            active_q <= 1'b1;
            is_div_q <= div_start_i;
            sign_q   <= prod_sign_i;
            x_sign_q <= x_sign_i;
            cnt_q    <= '0;
            acc_q    <= div_start_i ? {{MAG_W{1'b0}}, x_mag_i} : '0;
            mcand_q  <= {{MAG_W{1'b0}}, div_start_i ? y_mag_i : x_mag_i};
            mq_q     <= div_start_i ? '0 : y_mag_i;
        end else if (div_sat_i) begin
            quo_q <= oc_signed(prod_sign_i, {MAG_W{1'b1}});
        end else if (iter_done_o) begin
            active_q <= 1'b0;
            if (is_div_q) begin
                quo_q <= oc_signed(sign_q, mq_q);
            end else begin
                hi_q <= oc_signed(sign_q, acc_q[2*MAG_W-1:MAG_W]);
            end
        end else if (active_q) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (is_div_q) begin
                acc_q <= {{MAG_W{1'b0}}, div_fit ? div_diff[MAG_W-1:0] : rem2[MAG_W-1:0]};
                mq_q  <= {mq_q[MAG_W-2:0], div_fit};
            end else begin
                if (mq_q[0]) begin
                    acc_q <= mul_sum;
                end
                mcand_q <= mcand_q << 1;
                mq_q    <= mq_q >> 1;
            end
        end
    end

endmodule

// File: rtl/agc_alu_seq.sv
// agc_alu_seq: multi-cycle ones-complement ALU with start/done handshake.
// Option: ALU_MP_EARLY_TERM_EN (MP0 early termination, inside agc_muldiv_core).
module agc_alu_seq
    import agc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         alu_start,
    input  logic [2:0]   alu_op,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] y_in,
    output logic [W-1:0] result,
    output logic         busy,
    output logic         done,
    output logic         div_err
);

    state_t         state_q;
    logic [2:0]     op_q;
    logic [W-1:0]   x_q;
    logic [W-1:0]   y_q;
    logic [W-1:0]   result_q;
    logic           busy_q;
    logic           done_q;
    logic           div_err_q;

    logic             accept;
    logic             dv_bad;
    logic             mul_start;
    logic             div_start;
    logic             div_sat;
    logic [MAG_W-1:0] x_mag;
    logic [MAG_W-1:0] y_mag;
    logic [W-1:0]     exec_res;
    logic             core_done;
    logic [W-1:0]     lo_word;
    logic [W-1:0]     hi_word;
    logic [W-1:0]     quo_word;

    always_comb begin
        x_mag     = oc_mag(x_in);
        y_mag     = oc_mag(y_in);
        accept    = alu_start && (state_q == S_IDLE || state_q == S_FIN);
        dv_bad    = (x_mag >= y_mag);
        mul_start = accept && (alu_op == OP_MP0);
        div_start = accept && (alu_op == OP_DV0) && !dv_bad;
        div_sat   = accept && (alu_op == OP_DV0) && dv_bad;
    end

    // A rejected DV0 reports the unchanged dividend as its remainder.
    always_comb begin
        case (op_q)
            OP_AD:   exec_res = oc_add(x_q, y_q);
            OP_SU:   exec_res = oc_add(x_q, ~y_q);
            OP_MASK: exec_res = x_q & y_q;
            OP_MP1:  exec_res = hi_word;
            OP_DV0:  exec_res = x_q;
            OP_DV1:  exec_res = quo_word;
            default: exec_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_AD;
            x_q       <= '0;
            y_q       <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            div_err_q <= 1'b0;
        end else if (accept) begin
            op_q      <= alu_op;
            x_q       <= x_in;
            y_q       <= y_in;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            div_err_q <= 1'b0;
            state_q   <= mul_start ? S_MUL : (div_start ? S_DIV : S_EXEC);
        end else begin
            case (state_q)
                S_EXEC: begin
                    result_q  <= exec_res;
                    div_err_q <= (op_q == OP_DV0);
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= S_FIN;
                end
                S_MUL, S_DIV: begin
                    if (core_done) begin
                        result_q <= lo_word;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_FIN;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    agc_muldiv_core u_core (
        .clk         (clk),
        .rst         (rst),
        .mul_start_i (mul_start),
        .div_start_i (div_start),
        .div_sat_i   (div_sat),
        .x_mag_i     (x_mag),
        .y_mag_i     (y_mag),
        .prod_sign_i (x_in[W-1] ^ y_in[W-1]),
        .x_sign_i    (x_in[W-1]),
        .iter_done_o (core_done),
        .lo_word_o   (lo_word),
        .hi_word_o   (hi_word),
        .quo_word_o  (quo_word)
    );

    assign result  = result_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign div_err = div_err_q;

endmodule
